// File: rtl/mipspipe_hazard.sv
// mipspipe_hazard: 5-stage MIPS pipeline with full forwarding, load-use stall and BEQ flush.
// Define MIPSPIPE_PERF_EN to build the stall/flush performance counters.
module mipspipe_hazard #(
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024,
   parameter int CNT_W      = 32
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          imem_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   input  logic [31:0]                   imem_wdata,
   input  logic [4:0]                    dbg_raddr,
   output logic [31:0]                   dbg_rdata,
   output logic [31:0]                   pc_out,
   output logic                          stall_out,
   output logic                          flush_out,
   output logic [CNT_W-1:0]              retire_cnt,
   output logic [CNT_W-1:0]              stall_cnt,
   output logic [CNT_W-1:0]              flush_cnt
);
   localparam int IA = $clog2(IMEM_DEPTH);
   localparam int DA = $clog2(DMEM_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0020;
   localparam logic [5:0] OP_R = 6'd0, OP_BEQ = 6'd4, OP_LW = 6'd35, OP_SW = 6'd43;

   function automatic logic is_alu(input logic [5:0] op, input logic [5:0] fn);
      return op == OP_R && (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd42);
   endfunction

   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] dmem [DMEM_DEPTH];
   logic [31:0] regs_q [32];
   logic [31:0] pc_q, pc_d, ifid_ir_q, ifid_ir_d, ifid_pc_q, ifid_pc_d;
   logic [31:0] idex_ir_q, idex_ir_d, idex_pc_q, idex_pc_d, idex_a_q, idex_a_d, idex_b_q, idex_b_d;
   logic [31:0] exmem_ir_q, exmem_ir_d, exmem_alu_q, exmem_alu_d, exmem_b_q, exmem_b_d;
   logic [31:0] memwb_ir_q, memwb_ir_d, memwb_val_q, memwb_val_d;
   logic [CNT_W-1:0] retire_q, retire_d;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, wb_dst;
   logic [5:0] id_op, ex_op, ex_fn;
   logic [31:0] ain, bin, imm_x, alu;
   logic wb_alu, wb_we, em_alu, taken, lu;

   always_comb begin
      id_op = ifid_ir_q[31:26];
      id_rs = ifid_ir_q[25:21];
      id_rt = ifid_ir_q[20:16];
      ex_op = idex_ir_q[31:26];
      ex_rs = idex_ir_q[25:21];
      ex_rt = idex_ir_q[20:16];
      ex_fn = idex_ir_q[5:0];
      imm_x = {{16{idex_ir_q[15]}}, idex_ir_q[15:0]};
      wb_alu = is_alu(memwb_ir_q[31:26], memwb_ir_q[5:0]);
      wb_dst = wb_alu ? memwb_ir_q[15:11] : memwb_ir_q[20:16];
      wb_we = (wb_alu || memwb_ir_q[31:26] == OP_LW) && wb_dst != 5'd0;
      em_alu = is_alu(exmem_ir_q[31:26], exmem_ir_q[5:0]);
      // youngest producer wins: EX/MEM, then MEM/WB, then the value latched in ID
      ain = (ex_rs != 5'd0 && em_alu && exmem_ir_q[15:11] == ex_rs) ? exmem_alu_q
          : (wb_we && wb_dst == ex_rs) ? memwb_val_q : idex_a_q;
      bin = (ex_rt != 5'd0 && em_alu && exmem_ir_q[15:11] == ex_rt) ? exmem_alu_q
          : (wb_we && wb_dst == ex_rt) ? memwb_val_q : idex_b_q;
      alu = ex_op != OP_R  ? ain + imm_x
          : ex_fn == 6'd34 ? ain - bin
          : ex_fn == 6'd36 ? ain & bin
          : ex_fn == 6'd37 ? ain | bin
          : ex_fn == 6'd42 ? {31'd0, $signed(ain) < $signed(bin)}
          : ain + bin;
      taken = ex_op == OP_BEQ && ain == bin;
      lu = ex_op == OP_LW && ex_rt != 5'd0 &&
           (id_rs == ex_rt || ((id_op == OP_R || id_op == OP_SW || id_op == OP_BEQ) && id_rt == ex_rt));
      flush_out = taken;
      stall_out = lu && !taken;
      pc_d = taken ? idex_pc_q + 32'd4 + {imm_x[29:0], 2'b00} : stall_out ? pc_q : pc_q + 32'd4;
      ifid_ir_d = taken ? NOP : stall_out ? ifid_ir_q : imem[pc_q[IA+1:2]];
      ifid_pc_d = stall_out ? ifid_pc_q : pc_q;
      idex_ir_d = (taken || stall_out) ? NOP : ifid_ir_q;
      idex_pc_d = ifid_pc_q;
      idex_a_d = (wb_we && wb_dst == id_rs) ? memwb_val_q : regs_q[id_rs];
      idex_b_d = (wb_we && wb_dst == id_rt) ? memwb_val_q : regs_q[id_rt];
      exmem_ir_d = idex_ir_q;
      exmem_alu_d = alu;
      exmem_b_d = bin;
      memwb_ir_d = exmem_ir_q;
      memwb_val_d = exmem_ir_q[31:26] == OP_LW ? dmem[exmem_alu_q[DA+1:2]] : exmem_alu_q;
      retire_d = retire_q + CNT_W'(memwb_ir_q != NOP);
   end

   always_ff @(posedge clock) begin
      if (imem_we) imem[imem_addr] <= imem_wdata;
      if (reset_n && exmem_ir_q[31:26] == OP_SW) dmem[exmem_alu_q[DA+1:2]] <= exmem_b_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc_q <= '0;
         ifid_ir_q <= NOP;
         ifid_pc_q <= '0;
         idex_ir_q <= NOP;
         idex_pc_q <= '0;
         idex_a_q <= '0;
         idex_b_q <= '0;
         exmem_ir_q <= NOP;
         exmem_alu_q <= '0;
         exmem_b_q <= '0;
         memwb_ir_q <= NOP;
         memwb_val_q <= '0;
         retire_q <= '0;
         for (int i = 0; i < 32; i++) regs_q[i] <= 32'(i);
      end else begin
         pc_q <= pc_d;
         ifid_ir_q <= ifid_ir_d;
         ifid_pc_q <= ifid_pc_d;
         idex_ir_q <= idex_ir_d;
         idex_pc_q <= idex_pc_d;
         idex_a_q <= idex_a_d;
         idex_b_q <= idex_b_d;
         exmem_ir_q <= exmem_ir_d;
         exmem_alu_q <= exmem_alu_d;
         exmem_b_q <= exmem_b_d;
         memwb_ir_q <= memwb_ir_d;
         memwb_val_q <= memwb_val_d;
         retire_q <= retire_d;
         if (wb_we) regs_q[wb_dst] <= memwb_val_q;
      end
   end

   assign dbg_rdata = regs_q[dbg_raddr];
   assign pc_out = pc_q;
   assign retire_cnt = retire_q;

`ifdef MIPSPIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(stall_out);
      flush_cnt_d = flush_cnt_q + CNT_W'(flush_out);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_mipspipe_hazard.sv
// tb_mipspipe_hazard: directed pipeline scenarios plus random programs checked against
// an instruction-level interpreter of the MIPS subset.
module tb_mipspipe_hazard;
   localparam logic [31:0] NOP = 32'h0000_0020;
`ifdef MIPSPIPE_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clock = 1'b0, reset_n = 1'b0, imem_we = 1'b0;
   logic [9:0] imem_addr = '0;
   logic [31:0] imem_wdata = '0;
   logic [4:0] dbg_raddr = '0;
   logic [31:0] dbg_rdata, pc_out, retire_cnt, stall_cnt, flush_cnt;
   logic stall_out, flush_out;
   int errors = 0, checks = 0, stall_seen = 0, flush_seen = 0;
   logic [31:0] prog [$];
   logic [5:0] fn [5];

   always #5 clock = ~clock;

   mipspipe_hazard dut (
      .clock(clock), .reset_n(reset_n), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .pc_out(pc_out),
      .stall_out(stall_out), .flush_out(flush_out), .retire_cnt(retire_cnt),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always @(negedge clock) if (reset_n) begin
      stall_seen += int'(stall_out);
      flush_seen += int'(flush_out);
   end

   function automatic logic [31:0] r_op(input logic [5:0] f, input logic [4:0] rd, rs, rt);
      return {6'd0, rs, rt, rd, 5'd0, f};
   endfunction

   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
      dbg_raddr = r;
      #1;
      chk(tag, dbg_rdata, exp);
   endtask

   task automatic load();
      reset_n = 1'b0;
      for (int i = 0; i < 512; i++) begin
         imem_we = 1'b1;
         imem_addr = 10'(i);
         imem_wdata = (i < int'(prog.size())) ? prog[i] : NOP;
         tick(1);
      end
      imem_we = 1'b0;
      tick(1);
   endtask

   initial begin
      int s0, f0, pc, npc, plen, m_ret, m_stall, m_flush, c;
      logic [31:0] w, nx, va, vb, sx, res;
      logic [31:0] mr [32];
      logic [31:0] md [16];
      logic [4:0] rs, rt, rd, ra, rb;
      fn = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};

      // forwarding from EX/MEM, plus reset state
      prog.delete();
      prog.push_back(r_op(6'd32, 5'd5, 5'd2, 5'd1));
      prog.push_back(r_op(6'd32, 5'd6, 5'd5, 5'd5));
      load();
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_retire", retire_cnt, 32'd0);
      chk("rst_stall_out", 32'(stall_out), 32'd0);
      chk("rst_flush_out", 32'(flush_out), 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      chk("rst_flush_cnt", flush_cnt, 32'd0);
      chk_reg("rst_r17", 5'd17, 32'd17);
      s0 = stall_seen;
      reset_n = 1'b1;
      tick(20);
      chk_reg("t1_r5", 5'd5, 32'd3);
      chk_reg("t1_r6", 5'd6, 32'd6);
      chk("t1_retire", retire_cnt, 32'd2);
      chk("t1_stalls", 32'(stall_seen - s0), 32'd0);
      chk("t1_stall_cnt", stall_cnt, 32'd0);

      // load-use stall
      prog.delete();
      prog.push_back(r_op(6'd34, 5'd10, 5'd0, 5'd1));
      prog.push_back(i_op(6'd43, 5'd0, 5'd10, 16'd4));
      prog.push_back(i_op(6'd35, 5'd0, 5'd3, 16'd4));
      prog.push_back(r_op(6'd32, 5'd4, 5'd3, 5'd3));
      load();
      s0 = stall_seen;
      reset_n = 1'b1;
      tick(20);
      chk_reg("t2_r3", 5'd3, 32'hFFFF_FFFF);
      chk_reg("t2_r4", 5'd4, 32'hFFFF_FFFE);
      chk("t2_stalls", 32'(stall_seen - s0), 32'd1);
      chk("t2_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
      chk("t2_retire", retire_cnt, 32'd4);

      // store data forwarded
      prog.delete();
      prog.push_back(r_op(6'd32, 5'd7, 5'd8, 5'd9));
      prog.push_back(i_op(6'd43, 5'd0, 5'd7, 16'd8));
      prog.push_back(i_op(6'd35, 5'd0, 5'd11, 16'd8));
      load();
      s0 = stall_seen;
      reset_n = 1'b1;
      tick(20);
      chk_reg("t3_dmem2", 5'd11, 32'd17);
      chk("t3_stalls", 32'(stall_seen - s0), 32'd0);

      // taken branch at PC 0
      prog.delete();
      prog.push_back(i_op(6'd4, 5'd1, 5'd1, 16'd2));
      prog.push_back(r_op(6'd32, 5'd20, 5'd1, 5'd1));
      prog.push_back(r_op(6'd32, 5'd21, 5'd1, 5'd1));
      prog.push_back(r_op(6'd32, 5'd22, 5'd1, 5'd1));
      load();
      f0 = flush_seen;
      reset_n = 1'b1;
      tick(2);
      chk("t4_flush_hi", 32'(flush_out), 32'd1);
      chk("t4_pc_at_flush", pc_out, 32'd8);
      tick(1);
      chk("t4_flush_lo", 32'(flush_out), 32'd0);
      chk("t4_pc_target", pc_out, 32'd12);
      tick(20);
      chk_reg("t4_r20", 5'd20, 32'd20);
      chk_reg("t4_r21", 5'd21, 32'd21);
      chk_reg("t4_r22", 5'd22, 32'd2);
      chk("t4_flushes", 32'(flush_seen - f0), 32'd1);
      chk("t4_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
      chk("t4_retire", retire_cnt, 32'd2);

      // branch not taken
      prog[0] = i_op(6'd4, 5'd1, 5'd2, 16'd2);
      load();
      f0 = flush_seen;
      reset_n = 1'b1;
      tick(3);
      chk("t4n_pc3", pc_out, 32'd12);
      tick(1);
      chk("t4n_pc4", pc_out, 32'd16);
      tick(20);
      chk("t4n_flushes", 32'(flush_seen - f0), 32'd0);
      chk_reg("t4n_r20", 5'd20, 32'd2);
      chk_reg("t4n_r21", 5'd21, 32'd2);
      chk("t4n_retire", retire_cnt, 32'd4);

      // consumers in ID while the producer writes back, and one cycle later
      prog.delete();
      prog.push_back(r_op(6'd32, 5'd5, 5'd2, 5'd1));
      prog.push_back(NOP);
      prog.push_back(NOP);
      prog.push_back(r_op(6'd32, 5'd12, 5'd5, 5'd0));
      prog.push_back(r_op(6'd32, 5'd6, 5'd5, 5'd0));
      load();
      reset_n = 1'b1;
      tick(20);
      chk_reg("t5_r12", 5'd12, 32'd3);
      chk_reg("t5_r6", 5'd6, 32'd3);

      // mid-run reset
      prog.delete();
      prog.push_back(r_op(6'd32, 5'd5, 5'd2, 5'd1));
      prog.push_back(r_op(6'd32, 5'd6, 5'd5, 5'd5));
      load();
      reset_n = 1'b1;
      tick(6);
      chk("t6_pre_retire", retire_cnt, 32'd2);
      reset_n = 1'b0;
      tick(1);
      chk("t6_pc", pc_out, 32'd0);
      chk("t6_retire", retire_cnt, 32'd0);
      chk("t6_stall_out", 32'(stall_out), 32'd0);
      chk("t6_flush_out", 32'(flush_out), 32'd0);
      chk("t6_stall_cnt", stall_cnt, 32'd0);
      chk("t6_flush_cnt", flush_cnt, 32'd0);
      chk_reg("t6_r5", 5'd5, 32'd5);
      chk_reg("t6_r6", 5'd6, 32'd6);
      reset_n = 1'b1;
      tick(3);
      chk("t6_pipe_empty", retire_cnt, 32'd0);
      tick(20);
      chk_reg("t6_rerun_r5", 5'd5, 32'd3);
      chk_reg("t6_rerun_r6", 5'd6, 32'd6);
      chk("t6_rerun_retire", retire_cnt, 32'd2);

      // random programs vs interpreter
      for (int t = 0; t < 4; t++) begin
         prog.delete();
         for (int k = 0; k < 16; k++) prog.push_back(i_op(6'd43, 5'd0, 5'(k), 16'(4 * k)));
         for (int k = 0; k < 60; k++) begin
            c = int'($urandom_range(0, 9));
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            rd = 5'($urandom_range(1, 7));
            if (c < 5) w = r_op(fn[c], rd, ra, rb);
            else if (c < 7) w = i_op(6'd35, 5'd0, rd, 16'(4 * $urandom_range(0, 15)));
            else if (c < 8) w = i_op(6'd43, 5'd0, ra, 16'(4 * $urandom_range(0, 15)));
            else w = i_op(6'd4, ra, rb, 16'($urandom_range(0, 3)));
            prog.push_back(w);
         end
         for (int k = 16; k < 32; k++) prog.push_back(i_op(6'd35, 5'd0, 5'(k), 16'(4 * (k - 16))));
         plen = int'(prog.size());
         for (int i = 0; i < 32; i++) mr[i] = 32'(i);
         for (int i = 0; i < 16; i++) md[i] = '0;
         m_ret = 0;
         m_stall = 0;
         m_flush = 0;
         pc = 0;
         while (pc < plen) begin
            w = prog[pc];
            nx = (pc + 1 < plen) ? prog[pc + 1] : NOP;
            rs = w[25:21];
            rt = w[20:16];
            rd = w[15:11];
            va = mr[rs];
            vb = mr[rt];
            sx = {{16{w[15]}}, w[15:0]};
            npc = pc + 1;
            m_ret++;
            case (w[31:26])
               6'd0: begin
                  case (w[5:0])
                     6'd32: res = va + vb;
                     6'd34: res = va - vb;
                     6'd36: res = va & vb;
                     6'd37: res = va | vb;
                     default: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
                  endcase
                  if (rd != 5'd0) mr[rd] = res;
               end
               6'd35: begin
                  if (rt != 5'd0) mr[rt] = md[4'((va + sx) >> 2)];
                  if (rt != 5'd0 && (nx[25:21] == rt ||
                      ((nx[31:26] == 6'd0 || nx[31:26] == 6'd43 || nx[31:26] == 6'd4) && nx[20:16] == rt)))
                     m_stall++;
               end
               6'd43: md[4'((va + sx) >> 2)] = vb;
               6'd4: if (va == vb) begin
                  m_flush++;
                  npc = pc + 1 + int'($signed(sx));
               end
               default: ;
            endcase
            pc = npc;
         end
         load();
         s0 = stall_seen;
         f0 = flush_seen;
         reset_n = 1'b1;
         tick(300);
         for (int r = 0; r < 32; r++) chk_reg($sformatf("rand%0d_r%0d", t, r), 5'(r), mr[r]);
         chk($sformatf("rand%0d_retire", t), retire_cnt, 32'(m_ret));
         chk($sformatf("rand%0d_stalls", t), 32'(stall_seen - s0), 32'(m_stall));
         chk($sformatf("rand%0d_flushes", t), 32'(flush_seen - f0), 32'(m_flush));
         chk($sformatf("rand%0d_stall_cnt", t), stall_cnt, PERF ? 32'(m_stall) : 32'd0);
         chk($sformatf("rand%0d_flush_cnt", t), flush_cnt, PERF ? 32'(m_flush) : 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
